param_updown_counter: RTL
=========================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have parameter MAX_COUNT, default 255, giving the highest count value; legal range is 1 or greater.
REQ-002 The block SHALL have parameter PRESCALE, default 1, giving the enabled clocks per count step; legal range is 1 or greater.
REQ-003 The block SHALL have parameter RESET_VAL, default 0, giving the count value after reset; legal range is 0 to MAX_COUNT.
REQ-004 W SHALL equal $clog2(MAX_COUNT+1), with a minimum of 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port en, input, 1 bit: count enable, which gates the prescaler.
REQ-008 The block SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-010 The block SHALL have port load_val, input, W bits: value applied on load.
REQ-011 The block SHALL have port sat_mode, input, 1 bit: 1 = saturate at bounds, 0 = wrap.
REQ-012 The block SHALL have port count, output, W bits: current count, registered.
REQ-013 The block SHALL have port tc, output, 1 bit: terminal-count flag, combinational.
REQ-014 The block SHALL have port bound_evt, output, 1 bit: registered one-cycle pulse for a wrap or saturation event.
REQ-015 The block SHALL have ports ovf_sticky (output, 1 bit) and ovf_clr (input, 1 bit) only when COUNTER_OVF_STICKY_EN is defined.

Function
REQ-016 Priority per cycle SHALL be load > step > hold.
REQ-017 load=1 SHALL set count to min(load_val, MAX_COUNT) at the next edge, clear the prescaler to 0, and clear bound_evt to 0.
REQ-018 The prescaler (internal, 0..PRESCALE-1) SHALL advance only when en=1 and load=0, and SHALL wrap to 0 after PRESCALE-1.
REQ-019 A step SHALL occur in a cycle with en=1, load=0 and prescaler==PRESCALE-1; with PRESCALE=1, every en=1 cycle SHALL be a step.
REQ-020 On an up step with count<MAX_COUNT, count SHALL become count+1; on a down step with count>0, count SHALL become count-1.
REQ-021 On an up step with count==MAX_COUNT, count SHALL become 0 when sat_mode=0 and SHALL stay MAX_COUNT when sat_mode=1.
REQ-022 On a down step with count==0, count SHALL become MAX_COUNT when sat_mode=0 and SHALL stay 0 when sat_mode=1.
REQ-023 bound_evt SHALL be 1 in the cycle after any step covered by REQ-021 or REQ-022, and 0 otherwise.
REQ-024 tc SHALL be 1 when (up_dn=1 and count==MAX_COUNT) or (up_dn=0 and count==0), regardless of en.
REQ-025 With en=0, count and the prescaler SHALL hold; changes to up_dn or sat_mode SHALL take effect at the next step only.
REQ-026 Arithmetic SHALL be W-bit and SHALL never produce a value above MAX_COUNT, including when MAX_COUNT is not 2^W-1.

Reset
REQ-027 While rst_n=0, asynchronously: count SHALL be RESET_VAL, the prescaler 0, bound_evt 0, and ovf_sticky 0 if present.
REQ-028 Reset deassertion SHALL be used synchronously; the first step SHALL be possible no earlier than PRESCALE enabled cycles after release.
REQ-029 Reset asserted mid-operation SHALL override load, en and any pending step in the same cycle.

Configuration
REQ-030 With COUNTER_OVF_STICKY_EN defined, ovf_sticky SHALL set to 1 at the edge after any event that pulses bound_evt and hold until ovf_clr=1.
REQ-031 With COUNTER_OVF_STICKY_EN defined, when ovf_clr and a bound event coincide, ovf_sticky SHALL be 1 (set wins).
REQ-032 Without COUNTER_OVF_STICKY_EN, the ovf_sticky and ovf_clr ports and their logic SHALL be absent, with all other behaviour identical.

Verification
REQ-033 The bench SHALL cover: MAX_COUNT=9, PRESCALE=1, sat_mode=0, up, en=1 for 12 cycles from reset -> count 0..9,0,1, bound_evt one pulse after 9->0, tc=1 while count==9.
REQ-034 The bench SHALL cover: MAX_COUNT=9, sat_mode=1, down from 2, en=1 for 5 cycles -> count 1,0,0,0,0, bound_evt high for 3 cycles, tc=1 at 0.
REQ-035 The bench SHALL cover: PRESCALE=4, en=1, up from 0 -> count increments every 4th cycle; en dropped for 3 cycles -> prescaler and count frozen.
REQ-036 The bench SHALL cover: load=1 with load_val=200 on MAX_COUNT=150 while en=1 -> count=150, prescaler 0, no bound_evt; load and step in the same cycle -> load wins.
REQ-037 The bench SHALL cover: rst_n pulled low between clock edges mid-count -> count=RESET_VAL and bound_evt=0 immediately, no clock needed.
REQ-038 The bench SHALL cover: with COUNTER_OVF_STICKY_EN, a wrap -> ovf_sticky=1 held; ovf_clr coinciding with a second wrap -> stays 1; ovf_clr alone -> 0 next cycle.

Source files
------------

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Purpose  : Prescaled up/down counter with load, wrap/saturate bounds,
//            terminal-count flag and registered bound-event pulse.
// Option   : COUNTER_OVF_STICKY_EN adds ovf_sticky / ovf_clr.
// Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
  parameter int MAX_COUNT = 255,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0,
  localparam int W = ($clog2(MAX_COUNT + 1) < 1) ? 1 : $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         sat_mode,
  output logic [W-1:0] count,
  output logic         tc,
`ifdef COUNTER_OVF_STICKY_EN
  output logic         bound_evt,
  input  logic         ovf_clr,
  output logic         ovf_sticky
`else
  output logic         bound_evt
`endif
);

  localparam int            c_pw       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0]  c_max      = W'(MAX_COUNT);
  localparam logic [W-1:0]  c_reset    = W'(RESET_VAL);
  localparam logic [c_pw-1:0] c_pre_last = c_pw'(PRESCALE - 1);

  logic [W-1:0]    count_q, count_d;
  logic [c_pw-1:0] pre_q, pre_d;
  logic            bevt_q, bevt_d;
  logic            w_step;
  logic            w_at_bound;

  assign w_at_bound = up_dn ? (count_q == c_max) : (count_q == '0);
  assign w_step     = en && !load && (pre_q == c_pre_last);

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    bevt_d  = 1'b0;
    if (load) begin
      count_d = (load_val > c_max) ? c_max : load_val;
      pre_d   = '0;
    end else if (en) begin
      pre_d = (pre_q == c_pre_last) ? '0 : pre_q + 1'b1;
      if (w_step) begin
        bevt_d = w_at_bound;
        // At a bound: saturate holds, wrap jumps to the opposite bound
        if (w_at_bound) begin
          count_d = sat_mode ? count_q : (up_dn ? '0 : c_max);
        end else begin
          count_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= c_reset;
      pre_q   <= '0;
      bevt_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      bevt_q  <= bevt_d;
    end
  end

  assign count     = count_q;
  assign tc        = w_at_bound;
  assign bound_evt = bevt_q;

`ifdef COUNTER_OVF_STICKY_EN
  logic ovf_q;

  // A new bound event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bevt_d) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_sticky = ovf_q;
`endif

endmodule
`default_nettype wire
